mem_unit: RTL and testbench
===========================

Name: mem_unit

Overview:
- Consumer end of the execute-stage outputs: the EX/MEM pipeline register plus the memory-access stage.
- Captures EX results and control, runs a handshaked data-memory read or write (variable latency), and stalls upstream while the access is outstanding.
- Delivers registered write-back data/control to the WB stage and a return-address redirect to PC control for ret.

Parameters:
DATA_W, 32, data/EX result width
ADDR_W, 16, data-memory address width (low bits of address source)
REG_W, 5, destination register index width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ex_valid  in  1  EX stage presents a valid instruction
RegWrite_in  in  1  register write enable
MemWrite_in  in  1  memory write
MemRead_in  in  1  memory read
MemToReg_in  in  1  WB data select: 1 = memory read data, 0 = EX_out
MemSrc_in  in  1  address select: 1 = sp_in, 0 = EX_out
DestReg_in  in  REG_W  destination register (already 0x1B for call/ret)
EX_out  in  DATA_W  ALU/LI result
MemWrite_data_in  in  DATA_W  store data (PC for call)
sp_in  in  DATA_W  current stack pointer value
pop_in  in  1  pop instruction
ret_in  in  1  return instruction
branch_in  in  1  branch resolved in EX
mem_stall  out  1  hold EX/ID/IF; inputs must stay stable while high
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  ADDR_W  memory address
dmem_wdata  out  DATA_W  store data
dmem_rdata  in  DATA_W  read data, valid with dmem_ack
dmem_ack  in  1  access complete (one cycle)
wb_valid  out  1  WB register holds a valid instruction
wb_RegWrite  out  1  gated register write enable
wb_DestReg  out  REG_W  destination register
wb_data  out  DATA_W  write-back value
wb_pop  out  1  pop passthrough
wb_branch  out  1  branch passthrough
ret_pc_valid  out  1  one-cycle pulse: redirect PC
ret_pc  out  DATA_W  return address read from stack

Behaviour:
- Reset (rst_n=0 at edge): EX/MEM and WB valids clear; state IDLE; all outputs 0 (dmem_req, mem_stall, wb_*, ret_pc_valid, ret_pc, dmem_addr/wdata/we).
- Capture: at an edge with mem_stall=0, the EX/MEM register loads all *_in fields and valid=ex_valid. With ex_valid=0 a bubble is captured.
- mem_op = captured valid & (MemRead | MemWrite). MemRead & MemWrite both set: treated as write; a read is not issued.
- FSM states:
  - IDLE: no access outstanding. Enters ACCESS on the edge that captures a mem_op instruction.
  - ACCESS: dmem_req=1; dmem_we=MemWrite; dmem_addr = (MemSrc ? sp_in : EX_out)[ADDR_W-1:0], taken from the captured copy; dmem_wdata = captured store data. All are held constant until dmem_ack.
  - Transition out of ACCESS on the dmem_ack edge: to ACCESS again if a new mem_op is captured on the same edge, otherwise to IDLE.
- mem_stall = (state==ACCESS) & ~dmem_ack. Combinational; deasserts in the ack cycle so a back-to-back capture is possible.
- WB register load:
  - Loads at every edge where mem_stall=0.
  - wb_valid = captured valid.
  - wb_data = MemToReg ? dmem_rdata : EX_out.
  - wb_RegWrite = RegWrite & valid.
  - wb_pop and wb_branch are the captured values.
  - While stalled, the WB register loads a bubble (wb_valid=0, wb_RegWrite=0).
- Latency:
  - Non-memory instruction: WB output 2 edges after acceptance.
  - Memory instruction: WB output on the ack edge; minimum 2 edges with ack in the first ACCESS cycle.
- ret: on the ack edge of a ret read, ret_pc <= dmem_rdata and ret_pc_valid=1 for exactly one cycle.
- dmem_ack in IDLE (spurious or late after reset): ignored, no state or output change.
- Reset mid-access: dmem_req drops the cycle after reset, and the pending instruction is discarded with no WB and no ret pulse.
- Addresses wider than ADDR_W are truncated; there is no alignment check.

Decomposition:
- Shared cpu package holds:
  - FSM state encoding (IDLE, ACCESS).
  - SP register index constant 0x1B.
  - Width constants DATA_W, ADDR_W, REG_W.
- One natural sub-module, mem_fsm: request/stall state machine and dmem_req/ack handshake.
- The pipeline registers and muxes stay in mem_unit.

Test Plan:
- ALU op, no memory (EX_out=0x0000_1234, RegWrite=1, DestReg=3): wb_valid=1, wb_data=0x1234, wb_DestReg=3 two edges after acceptance; mem_stall never asserted.
- Load with ack after 3 ACCESS cycles (EX_out=0x0040, rdata=0xDEAD_BEEF, MemToReg=1): dmem_addr=0x0040, dmem_we=0, mem_stall high 2 cycles then low in the ack cycle; wb_data=0xDEAD_BEEF.
- Call push (MemWrite=1, MemSrc=1, sp_in=0x0000_FFF0, data=0x0000_0100): dmem_we=1, dmem_addr=0xFFF0, dmem_wdata=0x100; wb_RegWrite follows RegWrite_in.
- Ret (MemRead=1, ret=1, rdata=0x0000_0208): ret_pc_valid pulses for exactly one cycle with ret_pc=0x208.
- Back-to-back: store followed by load, ack 1 cycle each: the load is captured on the store's ack edge, and dmem_req stays high continuously with the address changing.
- rst_n=0 during ACCESS, then ack arrives after reset: dmem_req=0, wb_valid=0, no ret pulse, state remains IDLE.

Source files
------------

// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: shared widths, stack-pointer register index and memory FSM state encoding
package mem_unit_pkg;
    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 16;
    localparam int CPU_REG_W  = 5;
    localparam logic [CPU_REG_W-1:0] SP_REG = 5'h1B;
    typedef enum logic {IDLE, ACCESS} mem_state_t;
endpackage

// File: rtl/mem_fsm.sv
// mem_fsm: data-memory request/stall state machine
//   in : clk, rst_n (sync, active-low), new_op (EX presents a memory op), dmem_ack
//   out: dmem_req (access outstanding), mem_stall (hold upstream)
module mem_fsm
    import mem_unit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic new_op,
    input  logic dmem_ack,
    output logic dmem_req,
    output logic mem_stall
);
    mem_state_t state, next;
    assign dmem_req  = state == ACCESS;
    assign mem_stall = dmem_req & ~dmem_ack;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end
    // Capture only happens when not stalled, so a stall keeps ACCESS and an
    // unstalled edge enters ACCESS exactly when a new memory op is captured.
    always_comb begin
        next = IDLE;
        if (mem_stall || new_op) next = ACCESS;
    end
endmodule

// File: rtl/mem_unit.sv
// mem_unit: EX/MEM pipeline register, data-memory access stage and WB register
//   in : clk, rst_n (sync, active-low), ex_valid and the EX control/data *_in fields,
//        EX_out, MemWrite_data_in, sp_in, dmem_rdata, dmem_ack
//   out: mem_stall, dmem_req/we/addr/wdata, wb_valid/RegWrite/DestReg/data/pop/branch,
//        ret_pc_valid, ret_pc
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int REG_W  = CPU_REG_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              RegWrite_in,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              MemToReg_in,
    input  logic              MemSrc_in,
    input  logic [REG_W-1:0]  DestReg_in,
    input  logic [DATA_W-1:0] EX_out,
    input  logic [DATA_W-1:0] MemWrite_data_in,
    input  logic [DATA_W-1:0] sp_in,
    input  logic              pop_in,
    input  logic              ret_in,
    input  logic              branch_in,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [REG_W-1:0]  wb_DestReg,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_pop,
    output logic              wb_branch,
    output logic              ret_pc_valid,
    output logic [DATA_W-1:0] ret_pc
);
    logic              v_q, rw_q, mw_q, mr_q, m2r_q, pop_q, ret_q, br_q;
    logic [REG_W-1:0]  dest_q;
    logic [DATA_W-1:0] ex_q, wd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ret_hit;
    // Addresses are truncated to ADDR_W; the stack pointer's upper bits never matter.
    logic              unused_sp_hi;
    assign unused_sp_hi = |sp_in[DATA_W-1:ADDR_W];
    mem_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .new_op    (ex_valid & (MemRead_in | MemWrite_in)),
        .dmem_ack  (dmem_ack),
        .dmem_req  (dmem_req),
        .mem_stall (mem_stall)
    );
    assign dmem_we    = dmem_req & mw_q;
    assign dmem_addr  = dmem_req ? addr_q : '0;
    assign dmem_wdata = dmem_req ? wd_q : '0;
    // A read+write combination is a write, so it never redirects the PC.
    assign ret_hit    = dmem_req & dmem_ack & ret_q & mr_q & ~mw_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (!mem_stall) begin
            v_q    <= ex_valid;
            rw_q   <= RegWrite_in;
            mw_q   <= MemWrite_in;
            mr_q   <= MemRead_in;
            m2r_q  <= MemToReg_in;
            pop_q  <= pop_in;
            ret_q  <= ret_in;
            br_q   <= branch_in;
            dest_q <= DestReg_in;
            ex_q   <= EX_out;
            wd_q   <= MemWrite_data_in;
            addr_q <= MemSrc_in ? sp_in[ADDR_W-1:0] : EX_out[ADDR_W-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_RegWrite  <= 1'b0;
            wb_DestReg   <= '0;
            wb_data      <= '0;
            wb_pop       <= 1'b0;
            wb_branch    <= 1'b0;
            ret_pc_valid <= 1'b0;
            ret_pc       <= '0;
        end else begin
            ret_pc_valid <= ret_hit;
            if (ret_hit) ret_pc <= dmem_rdata;
            if (!mem_stall) begin
                wb_valid    <= v_q;
                wb_RegWrite <= rw_q & v_q;
                wb_DestReg  <= dest_q;
                wb_data     <= m2r_q ? dmem_rdata : ex_q;
                wb_pop      <= pop_q;
                wb_branch   <= br_q;
            end else begin
                wb_valid    <= 1'b0;
                wb_RegWrite <= 1'b0;
                wb_pop      <= 1'b0;
                wb_branch   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
// tb_mem_unit: directed and randomized instruction stream against a transaction-level model
module tb_mem_unit;
    import mem_unit_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid, RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in;
    logic [4:0]  DestReg_in;
    logic [31:0] EX_out, MemWrite_data_in, sp_in;
    logic        pop_in, ret_in, branch_in;
    logic        mem_stall, dmem_req, dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid, wb_RegWrite;
    logic [4:0]  wb_DestReg;
    logic [31:0] wb_data;
    logic        wb_pop, wb_branch, ret_pc_valid;
    logic [31:0] ret_pc;

    mem_unit dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .RegWrite_in(RegWrite_in),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .MemToReg_in(MemToReg_in),
        .MemSrc_in(MemSrc_in), .DestReg_in(DestReg_in), .EX_out(EX_out),
        .MemWrite_data_in(MemWrite_data_in), .sp_in(sp_in), .pop_in(pop_in),
        .ret_in(ret_in), .branch_in(branch_in), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_DestReg(wb_DestReg),
        .wb_data(wb_data), .wb_pop(wb_pop), .wb_branch(wb_branch),
        .ret_pc_valid(ret_pc_valid), .ret_pc(ret_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v, rw, mw, mr, m2r, msrc, pop, ret, br;
        logic [4:0]  dest;
        logic [31:0] ex, wd, sp;
    } ins_t;

    ins_t        nop, last, cur;
    int          checks = 0, errors = 0;
    bit          pend;
    int          p_lat, next_lat;
    logic [31:0] exp_ret_pc;
    logic [31:0] mem_m [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] addr_of(input ins_t i);
        return 16'((i.msrc ? i.sp : i.ex) % 32'h10000);
    endfunction

    task automatic drive(input ins_t c);
        ex_valid = c.v; RegWrite_in = c.rw; MemWrite_in = c.mw; MemRead_in = c.mr;
        MemToReg_in = c.m2r; MemSrc_in = c.msrc; DestReg_in = c.dest; EX_out = c.ex;
        MemWrite_data_in = c.wd; sp_in = c.sp; pop_in = c.pop; ret_in = c.ret; branch_in = c.br;
    endtask

    // One clock: the model knows which instruction sits in the memory stage
    // ("last"), whether its access is outstanding, and when the memory acks.
    task automatic cycle(input bit have, output bit acc);
        ins_t        c, prev;
        logic        ack;
        logic [31:0] rd;
        logic [15:0] a;
        bit          stall, rh, ev;
        c    = have ? cur : nop;
        prev = last;
        drive(c);
        a   = addr_of(prev);
        ack = pend ? (p_lat == 0) : ($urandom_range(0, 9) == 0);
        rd  = $urandom;
        if (pend && ack && prev.mr && !prev.mw) begin
            if (!mem_m.exists(int'(a))) mem_m[int'(a)] = $urandom;
            rd = mem_m[int'(a)];
        end
        dmem_ack   = ack;
        dmem_rdata = rd;
        #1;
        stall = pend && !ack;
        chk("mem_stall", 32'(mem_stall), 32'(stall));
        chk("dmem_req", 32'(dmem_req), 32'(pend));
        if (pend) begin
            chk("dmem_addr", 32'(dmem_addr), 32'(a));
            chk("dmem_we", 32'(dmem_we), 32'(prev.mw));
            chk("dmem_wdata", dmem_wdata, prev.wd);
        end
        ev = !stall && prev.v;
        rh = pend && ack && prev.ret && prev.mr && !prev.mw;
        if (rh) exp_ret_pc = rd;
        if (pend && ack && prev.mw) mem_m[int'(a)] = prev.wd;
        acc = have && !stall;
        if (stall) p_lat--;
        else begin
            last  = c;
            pend  = c.v && (c.mr || c.mw);
            p_lat = next_lat;
        end
        @(posedge clk);
        @(negedge clk);
        chk("wb_valid", 32'(wb_valid), 32'(ev));
        chk("wb_RegWrite", 32'(wb_RegWrite), 32'(ev && prev.rw));
        if (ev) begin
            chk("wb_DestReg", 32'(wb_DestReg), 32'(prev.dest));
            chk("wb_data", wb_data, prev.m2r ? rd : prev.ex);
            chk("wb_pop", 32'(wb_pop), 32'(prev.pop));
            chk("wb_branch", 32'(wb_branch), 32'(prev.br));
        end
        chk("ret_pc_valid", 32'(ret_pc_valid), 32'(rh));
        chk("ret_pc", ret_pc, exp_ret_pc);
    endtask

    task automatic issue(input ins_t c, input int lat);
        bit ok = 1'b0;
        int n  = 0;
        cur      = c;
        next_lat = lat;
        while (!ok && n < 20) begin
            cycle(1'b1, ok);
            n++;
        end
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        bit ok;
        repeat (n) cycle(1'b0, ok);
    endtask

    function automatic ins_t rnd();
        ins_t r;
        int   k;
        r    = nop;
        k    = $urandom_range(0, 3);
        r.v  = 1'b1;
        r.mr = (k == 1) || (k == 3);
        r.mw = (k == 2) || (k == 3);
        r.rw = 1'($urandom);
        r.m2r  = r.mr ? 1'($urandom) : ($urandom_range(0, 7) == 0);
        r.msrc = 1'($urandom);
        r.pop  = 1'($urandom);
        r.ret  = r.mr && 1'($urandom);
        r.br   = 1'($urandom);
        r.dest = 5'($urandom);
        r.ex   = ($urandom & 32'hFFFF_0000) | (32'h100 + 4 * $urandom_range(0, 7));
        r.sp   = ($urandom & 32'hFFFF_0000) | (32'h100 + 4 * $urandom_range(0, 7));
        r.wd   = $urandom;
        return r;
    endfunction

    initial begin
        ins_t t, s;
        nop        = '{default: '0};
        last       = nop;
        pend       = 1'b0;
        p_lat      = 0;
        next_lat   = 0;
        exp_ret_pc = '0;
        drive(nop);
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst dmem_req", 32'(dmem_req), 0);
        chk("rst mem_stall", 32'(mem_stall), 0);
        chk("rst dmem_we", 32'(dmem_we), 0);
        chk("rst dmem_addr", 32'(dmem_addr), 0);
        chk("rst dmem_wdata", dmem_wdata, 0);
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst wb_RegWrite", 32'(wb_RegWrite), 0);
        chk("rst wb_data", wb_data, 0);
        chk("rst wb_DestReg", 32'(wb_DestReg), 0);
        chk("rst ret_pc_valid", 32'(ret_pc_valid), 0);
        chk("rst ret_pc", ret_pc, 0);
        rst_n = 1'b1;
        // ALU op, no memory access
        t = nop; t.v = 1; t.rw = 1; t.dest = 5'd3; t.ex = 32'h0000_1234;
        issue(t, 0);
        idle(2);
        // Load acked in the third access cycle
        mem_m[32'h40] = 32'hDEAD_BEEF;
        t = nop; t.v = 1; t.mr = 1; t.m2r = 1; t.rw = 1; t.dest = 5'd5; t.ex = 32'h0000_0040;
        issue(t, 2);
        idle(3);
        // Call push through the stack pointer
        t = nop; t.v = 1; t.mw = 1; t.msrc = 1; t.rw = 1; t.dest = SP_REG;
        t.sp = 32'h0000_FFF0; t.wd = 32'h0000_0100; t.ex = 32'h0000_FFEC;
        issue(t, 1);
        idle(3);
        // Ret reads the return address
        mem_m[32'hFFF4] = 32'h0000_0208;
        t = nop; t.v = 1; t.mr = 1; t.ret = 1; t.msrc = 1; t.dest = SP_REG; t.sp = 32'h0000_FFF4;
        issue(t, 0);
        idle(3);
        // Store then load back-to-back, one-cycle acks
        s = nop; s.v = 1; s.mw = 1; s.ex = 32'h0000_0200; s.wd = 32'hCAFE_0001;
        t = nop; t.v = 1; t.mr = 1; t.m2r = 1; t.rw = 1; t.dest = 5'd7; t.ex = 32'h0000_0204;
        issue(s, 0);
        issue(t, 0);
        t.ex = 32'h0001_0200;
        issue(t, 0);
        idle(3);
        // Randomized stream with variable memory latency
        repeat (200) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(rnd(), $urandom_range(0, 3));
        end
        idle(4);
        // Reset in the middle of a ret read, then a late ack
        t = nop; t.v = 1; t.mr = 1; t.ret = 1; t.m2r = 1; t.rw = 1; t.ex = 32'h0000_0044;
        issue(t, 3);
        idle(1);
        rst_n = 1'b0;
        drive(nop);
        dmem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        pend       = 1'b0;
        last       = nop;
        exp_ret_pc = '0;
        chk("midrst dmem_req", 32'(dmem_req), 0);
        chk("midrst wb_valid", 32'(wb_valid), 0);
        chk("midrst ret_pc_valid", 32'(ret_pc_valid), 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_0208;
        #1;
        chk("late ack mem_stall", 32'(mem_stall), 0);
        chk("late ack dmem_req", 32'(dmem_req), 0);
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late ack dmem_req after", 32'(dmem_req), 0);
        chk("late ack wb_valid", 32'(wb_valid), 0);
        chk("late ack ret_pc_valid", 32'(ret_pc_valid), 0);
        chk("late ack ret_pc", ret_pc, 0);
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
